// File: rtl/msx_mouse_host.sv
// rtl/msx_mouse_host.sv - MSX mouse host: strobes the mouse four times and assembles dx/dy/buttons
module msx_mouse_host #(
    parameter int SETTLE_CYCLES = 64,
    parameter int POLL_PERIOD   = 400000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] port_in,
    output logic       strobe,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] buttons,
    output logic       valid,
    output logic       busy
);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOGGLE = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    dx_q, dx_d;
    logic [7:0]    dy_q, dy_d;
    logic [1:0]    buttons_q, buttons_d;
    logic          valid_q, valid_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [1:0]    k_q, k_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [1:0]    btn_shadow_q, btn_shadow_d;

    logic start;
    logic settle_done;

    assign start       = (state_q == IDLE) && (req || (poll_q == POLL_LAST));
    assign settle_done = (settle_q == SETTLE_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            strobe_q     <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            buttons_q    <= '0;
            valid_q      <= 1'b0;
            poll_q       <= '0;
            settle_q     <= '0;
            k_q          <= '0;
            shadow_q     <= '0;
            btn_shadow_q <= '0;
        end else begin
            state_q      <= state_d;
            strobe_q     <= strobe_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            buttons_q    <= buttons_d;
            valid_q      <= valid_d;
            poll_q       <= poll_d;
            settle_q     <= settle_d;
            k_q          <= k_d;
            shadow_q     <= shadow_d;
            btn_shadow_q <= btn_shadow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = TOGGLE;
            TOGGLE:  state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = SAMPLE;
            SAMPLE:  state_d = (k_q == 2'd3) ? DONE : TOGGLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The poll counter only advances in IDLE, so the poll period excludes transaction time.
    always_comb begin
        strobe_d     = strobe_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        buttons_d    = buttons_q;
        valid_d      = 1'b0;
        poll_d       = poll_q;
        settle_d     = settle_q;
        k_d          = k_q;
        shadow_d     = shadow_q;
        btn_shadow_d = btn_shadow_q;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                poll_d = start ? '0 : poll_q + PW'(1);
            end
            TOGGLE: begin
                strobe_d = ~strobe_q;
                settle_d = '0;
            end
            SETTLE: begin
                if (!settle_done) settle_d = settle_q + SW'(1);
            end
            SAMPLE: begin
                case (k_q)
                    2'd0:    shadow_d[15:12] = ~port_in[3:0];
                    2'd1:    shadow_d[11:8]  = ~port_in[3:0];
                    2'd2:    shadow_d[7:4]   = ~port_in[3:0];
                    default: begin
                        shadow_d[3:0] = ~port_in[3:0];
                        btn_shadow_d  = ~port_in[5:4];
                    end
                endcase
                k_d = k_q + 2'd1;
            end
            DONE: begin
                dx_d      = shadow_q[15:8];
                dy_d      = shadow_q[7:0];
                buttons_d = btn_shadow_q;
                valid_d   = 1'b1;
                k_d       = '0;
            end
            default: ;
        endcase
    end

    assign strobe  = strobe_q;
    assign dx      = dx_q;
    assign dy      = dy_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_msx_mouse_host.sv
// tb/tb_msx_mouse_host.sv - self-checking bench for msx_mouse_host with a behavioural mouse responder
module tb_msx_mouse_host;
    localparam int P   = 2000;
    localparam int S   = 64;
    localparam int LAT = 4 * (S + 2) + 1;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       req     = 1'b0;
    logic       req1    = 1'b0;
    logic [5:0] port_in0 = 6'h3F;
    logic [5:0] port_in1 = 6'h3F;
    logic       strobe0, valid0, busy0, strobe1, valid1, busy1;
    logic [7:0] dx0, dy0, dx1, dy1;
    logic [1:0] buttons0, buttons1;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    msx_mouse_host #(.SETTLE_CYCLES(S), .POLL_PERIOD(P)) u0 (
        .clk_sys(clk_sys), .reset(reset), .req(req), .port_in(port_in0),
        .strobe(strobe0), .dx(dx0), .dy(dy0), .buttons(buttons0),
        .valid(valid0), .busy(busy0)
    );

    msx_mouse_host #(.SETTLE_CYCLES(1), .POLL_PERIOD(P)) u1 (
        .clk_sys(clk_sys), .reset(reset), .req(req1), .port_in(port_in1),
        .strobe(strobe1), .dx(dx1), .dy(dy1), .buttons(buttons1),
        .valid(valid1), .busy(busy1)
    );

    // Mouse responder: each strobe edge presents the next nibble; a long quiet strobe resyncs it.
    logic [7:0] m_dx = 8'h00;
    logic [7:0] m_dy = 8'h00;
    logic [1:0] m_pins = 2'b11;
    int         m_idx = 0;
    int         m_quiet = 0;
    logic       strobe0_prev = 1'b0;
    logic       strobe1_prev = 1'b0;
    int         edge_cnt = 0;
    int         valid_cnt = 0;
    int         cyc = 0;
    logic [5:0] hist [0:4095];
    int         e1q[$];

    function automatic logic [3:0] nib(input int i);
        case (i)
            0:       return m_dx[7:4];
            1:       return m_dx[3:0];
            2:       return m_dy[7:4];
            default: return m_dy[3:0];
        endcase
    endfunction

    always @(posedge clk_sys) begin
        #1;
        cyc = cyc + 1;
        port_in1 = 6'($urandom);
        hist[cyc % 4096] = port_in1;
        if (strobe1 !== strobe1_prev) e1q.push_back(cyc);
        strobe1_prev = strobe1;
        if (strobe0 !== strobe0_prev) begin
            port_in0 = {m_pins, ~nib(m_idx)};
            m_idx = (m_idx + 1) % 4;
            m_quiet = 0;
            edge_cnt = edge_cnt + 1;
        end else if (m_quiet >= 1000) begin
            m_idx = 0;
        end else begin
            m_quiet = m_quiet + 1;
        end
        strobe0_prev = strobe0;
        if (valid0 === 1'b1) valid_cnt = valid_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic set_mouse(input logic [7:0] x, input logic [7:0] y, input logic [1:0] pins);
        m_dx = x;
        m_dy = y;
        m_pins = pins;
        port_in0[5:4] = pins;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_valid0(input int bound, output int vc, output bit ok);
        ok = 1'b0;
        vc = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (valid0 === 1'b1) begin
                ok = 1'b1;
                vc = cyc;
                return;
            end
        end
    endtask

    task automatic do_txn(input logic [7:0] x, input logic [7:0] y, input logic [1:0] pins,
                          output bit ok, output int lat);
        int st;
        int vc;
        set_mouse(x, y, pins);
        repeat (1100) tick();
        pulse_req();
        st = cyc;
        wait_valid0(LAT + 50, vc, ok);
        lat = vc - st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (strobe0 !== 1'b0)  begin failures++; $display("FAIL reset_strobe got=%0h exp=0", strobe0); end
        checks++; if (dx0 !== 8'h00)     begin failures++; $display("FAIL reset_dx got=%0h exp=0", dx0); end
        checks++; if (dy0 !== 8'h00)     begin failures++; $display("FAIL reset_dy got=%0h exp=0", dy0); end
        checks++; if (buttons0 !== 2'b0) begin failures++; $display("FAIL reset_buttons got=%0h exp=0", buttons0); end
        checks++; if (valid0 !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid0); end
        checks++; if (busy0 !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy0); end
        reset = 1'b0;
    endtask

    task automatic test_req_basic();
        logic [7:0] pdx, pdy;
        bit ok, early;
        int st, vc, e0;
        set_mouse(8'h05, 8'hFB, 2'b10);
        repeat (1100) tick();
        pdx = dx0;
        pdy = dy0;
        e0 = edge_cnt;
        pulse_req();
        st = cyc;
        ok = 1'b0;
        early = 1'b0;
        vc = 0;
        for (int i = 0; i < LAT + 50; i++) begin
            tick();
            if (valid0 === 1'b1) begin ok = 1'b1; vc = cyc; break; end
            if (dx0 !== pdx || dy0 !== pdy) early = 1'b1;
        end
        checks++; if (!ok)              begin failures++; $display("FAIL basic_valid_timeout got=none exp=valid"); end
        checks++; if (vc - st !== LAT)  begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", vc - st, LAT); end
        checks++; if (dx0 !== 8'h05)    begin failures++; $display("FAIL basic_dx got=%0h exp=05", dx0); end
        checks++; if (dy0 !== 8'hFB)    begin failures++; $display("FAIL basic_dy got=%0h exp=fb", dy0); end
        checks++; if (buttons0 !== 2'b01) begin failures++; $display("FAIL basic_buttons got=%0b exp=01", buttons0); end
        checks++; if (strobe0 !== 1'b0) begin failures++; $display("FAIL basic_strobe_end got=%0b exp=0", strobe0); end
        checks++; if (edge_cnt - e0 !== 4) begin failures++; $display("FAIL basic_edges got=%0d exp=4", edge_cnt - e0); end
        checks++; if (early)            begin failures++; $display("FAIL basic_early_update got=1 exp=0"); end
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic [1:0] p;
        bit ok;
        int lat;
        for (int n = 0; n < 5; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            p = 2'($urandom);
            do_txn(x, y, p, ok, lat);
            checks++; if (!ok || lat !== LAT) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, lat, LAT); end
            checks++; if (dx0 !== x || dy0 !== y) begin failures++; $display("FAIL rand_xy[%0d] got=%0h/%0h exp=%0h/%0h", n, dx0, dy0, x, y); end
            checks++; if (buttons0 !== ~p) begin failures++; $display("FAIL rand_buttons[%0d] got=%0b exp=%0b", n, buttons0, ~p); end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int lat;
        do_txn(8'h80, 8'h7F, 2'b00, ok, lat);
        checks++; if (!ok)               begin failures++; $display("FAIL ext_valid got=none exp=valid"); end
        checks++; if (dx0 !== 8'h80)     begin failures++; $display("FAIL ext_dx got=%0h exp=80", dx0); end
        checks++; if (dy0 !== 8'h7F)     begin failures++; $display("FAIL ext_dy got=%0h exp=7f", dy0); end
        checks++; if (buttons0 !== 2'b11) begin failures++; $display("FAIL ext_buttons got=%0b exp=11", buttons0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        int st, v, e;
        x = 8'($urandom);
        y = 8'($urandom);
        set_mouse(x, y, 2'b01);
        repeat (1100) tick();
        v = valid_cnt;
        e = edge_cnt;
        pulse_req();
        st = cyc;
        while (cyc < st + 9) tick();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy0); end
        pulse_req();
        while (cyc < st + 99) tick();
        pulse_req();
        while (cyc < st + 400) tick();
        checks++; if (valid_cnt - v !== 1) begin failures++; $display("FAIL b2b_valids got=%0d exp=1", valid_cnt - v); end
        checks++; if (edge_cnt - e !== 4)  begin failures++; $display("FAIL b2b_edges got=%0d exp=4", edge_cnt - e); end
        checks++; if (dx0 !== x || dy0 !== y) begin failures++; $display("FAIL b2b_xy got=%0h/%0h exp=%0h/%0h", dx0, dy0, x, y); end
    endtask

    task automatic test_poll();
        logic [7:0] x, y;
        int rel, v1, v2, v3, ve, ee;
        bit ok1, ok2, ok3;
        x = 8'($urandom);
        y = 8'($urandom);
        set_mouse(x, y, 2'b11);
        reset = 1'b1;
        tick();
        tick();
        rel = cyc;
        reset = 1'b0;
        wait_valid0(P + 400, v1, ok1);
        checks++; if (!ok1 || v1 - rel !== P + LAT) begin failures++; $display("FAIL poll_first got=%0d exp=%0d", v1 - rel, P + LAT); end
        checks++; if (dx0 !== x || dy0 !== y) begin failures++; $display("FAIL poll_xy got=%0h/%0h exp=%0h/%0h", dx0, dy0, x, y); end
        wait_valid0(P + 400, v2, ok2);
        checks++; if (!ok2 || v2 - v1 !== P + LAT) begin failures++; $display("FAIL poll_period got=%0d exp=%0d", v2 - v1, P + LAT); end
        while (cyc < v2 + P - 1) tick();
        ve = valid_cnt;
        ee = edge_cnt;
        pulse_req();
        wait_valid0(LAT + 50, v3, ok3);
        checks++; if (!ok3 || v3 - v2 !== P + LAT) begin failures++; $display("FAIL coincide_start got=%0d exp=%0d", v3 - v2, P + LAT); end
        repeat (300) tick();
        checks++; if (valid_cnt - ve !== 1) begin failures++; $display("FAIL coincide_valids got=%0d exp=1", valid_cnt - ve); end
        checks++; if (edge_cnt - ee !== 4)  begin failures++; $display("FAIL coincide_edges got=%0d exp=4", edge_cnt - ee); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] x, y;
        bit ok;
        int st, v, lat;
        set_mouse(8'($urandom), 8'($urandom), 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (1100) tick();
        pulse_req();
        st = cyc;
        v = valid_cnt;
        while (cyc < st + 140) tick();
        checks++; if (strobe0 !== 1'b1) begin failures++; $display("FAIL abort_pre_strobe got=%0b exp=1", strobe0); end
        reset = 1'b1;
        tick();
        checks++; if (strobe0 !== 1'b0) begin failures++; $display("FAIL abort_strobe got=%0b exp=0", strobe0); end
        checks++; if (dx0 !== 8'h00)    begin failures++; $display("FAIL abort_dx got=%0h exp=0", dx0); end
        checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL abort_valid_busy got=%0b%0b exp=00", valid0, busy0); end
        reset = 1'b0;
        repeat (400) tick();
        checks++; if (valid_cnt !== v) begin failures++; $display("FAIL abort_no_valid got=%0d exp=%0d", valid_cnt, v); end
        x = 8'($urandom);
        y = 8'($urandom);
        do_txn(x, y, 2'b01, ok, lat);
        checks++; if (!ok || dx0 !== x || dy0 !== y) begin failures++; $display("FAIL abort_recover got=%0h/%0h exp=%0h/%0h", dx0, dy0, x, y); end
        checks++; if (buttons0 !== 2'b10) begin failures++; $display("FAIL abort_buttons got=%0b exp=10", buttons0); end
    endtask

    task automatic test_settle_one();
        int st, vc;
        bit ok;
        logic [7:0] ex, ey;
        logic [1:0] eb;
        logic [5:0] h0, h1, h2, h3;
        for (int i = 0; i < 100 && busy1 === 1'b1; i++) tick();
        e1q.delete();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        st = cyc;
        ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid1 === 1'b1) begin ok = 1'b1; vc = cyc; break; end
        end
        checks++; if (!ok || vc - st !== 13) begin failures++; $display("FAIL s1_latency got=%0d exp=13", vc - st); end
        checks++; if (e1q.size() !== 4) begin failures++; $display("FAIL s1_edges got=%0d exp=4", e1q.size()); end
        if (e1q.size() >= 4) begin
            h0 = hist[(e1q[0] + 1) % 4096];
            h1 = hist[(e1q[1] + 1) % 4096];
            h2 = hist[(e1q[2] + 1) % 4096];
            h3 = hist[(e1q[3] + 1) % 4096];
            ex = ~{h0[3:0], h1[3:0]};
            ey = ~{h2[3:0], h3[3:0]};
            eb = ~h3[5:4];
            checks++; if (dx1 !== ex) begin failures++; $display("FAIL s1_dx got=%0h exp=%0h", dx1, ex); end
            checks++; if (dy1 !== ey) begin failures++; $display("FAIL s1_dy got=%0h exp=%0h", dy1, ey); end
            checks++; if (buttons1 !== eb) begin failures++; $display("FAIL s1_buttons got=%0b exp=%0b", buttons1, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_req_basic();
        test_random();
        test_extremes();
        test_back_to_back();
        test_poll();
        test_reset_abort();
        test_settle_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
